// File: rtl/traffic_light_pkg.sv
// Shared types for the two-way intersection controller:
// phase encoding and the phase-to-lamp decode.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    EMERG_RED = 3'd4
  } state_t;

  // Lamp vector order: {NS_G, NS_Y, EW_G, EW_Y}; red is implied.
  function automatic logic [3:0] lamps(state_t s);
    logic [3:0] v;
    v = 4'b0000;
    case (s)
      NS_GREEN:  v = 4'b1000;
      NS_YELLOW: v = 4'b0100;
      EW_GREEN:  v = 4'b0010;
      EW_YELLOW: v = 4'b0001;
      default:   v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_light_tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV clocks.
// A clear restarts the count so each phase starts on a fresh tick period.
module tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light.sv
// Two-way intersection controller with emergency all-red override.
// Phase FSM, tick-based phase timer and registered lamp decode.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic emergency,
  output logic NS_G,
  output logic NS_Y,
  output logic EW_G,
  output logic EW_Y
);

  localparam int MAXT =
    (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int TW = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [TW-1:0] G_LAST = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_TICKS - 1);

  state_t        state;
  state_t        nxt;
  logic [TW-1:0] timer;
  logic [3:0]    lamp;
  logic          tick;
  logic          done_g;
  logic          done_y;
  logic          change;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clear(change),
    .tick (tick)
  );

  assign done_g = tick && (timer == G_LAST);
  assign done_y = tick && (timer == Y_LAST);
  assign change = (nxt != state);

  // Greens yield at once to emergency; yellows always run full length.
  always_comb begin
    nxt = state;
    case (state)
      NS_GREEN:
        if (emergency || done_g) nxt = NS_YELLOW;
      NS_YELLOW:
        if (done_y) nxt = emergency ? EMERG_RED : EW_GREEN;
      EW_GREEN:
        if (emergency || done_g) nxt = EW_YELLOW;
      EW_YELLOW:
        if (done_y) nxt = emergency ? EMERG_RED : NS_GREEN;
      EMERG_RED:
        if (!emergency) nxt = NS_GREEN;
      default:
        nxt = NS_GREEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NS_GREEN;
      timer <= '0;
      lamp  <= lamps(NS_GREEN);
    end else begin
      state <= nxt;
      lamp  <= lamps(nxt);
      if (change) begin
        timer <= '0;
      end else if (tick && state != EMERG_RED) begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign {NS_G, NS_Y, EW_G, EW_Y} = lamp;

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: default and fast-override instances
// checked every cycle against a clock-count phase model.
module tb_traffic_light;

  logic clk;
  logic reset;
  logic emergency;
  logic emergency2;
  logic ns_g1, ns_y1, ew_g1, ew_y1;
  logic ns_g2, ns_y2, ew_g2, ew_y2;
  logic [3:0] l1, l2;

  int n_chk;
  int n_fail;
  int cur;

  traffic_light dut (
    .clk      (clk),
    .reset    (reset),
    .emergency(emergency),
    .NS_G     (ns_g1),
    .NS_Y     (ns_y1),
    .EW_G     (ew_g1),
    .EW_Y     (ew_y1)
  );

  traffic_light #(
    .TICK_DIV    (1),
    .GREEN_TICKS (2),
    .YELLOW_TICKS(1)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .emergency(emergency2),
    .NS_G     (ns_g2),
    .NS_Y     (ns_y2),
    .EW_G     (ew_g2),
    .EW_Y     (ew_y2)
  );

  assign l1 = {ns_g1, ns_y1, ew_g1, ew_y1};
  assign l2 = {ns_g2, ns_y2, ew_g2, ew_y2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 NSG, 1 NSY, 2 EWG, 3 EWY, 4 all-red;
  // el = clocks already spent in the phase.
  typedef struct packed {
    int ph;
    int el;
  } mst_t;

  mst_t m1, m2;

  function automatic mst_t step_m(mst_t m, logic e, int glen, int ylen);
    mst_t r;
    r = m;
    if (m.ph == 0 || m.ph == 2) begin
      if (e || m.el + 1 == glen) begin
        r.ph = m.ph + 1;
        r.el = 0;
      end else begin
        r.el = m.el + 1;
      end
    end else if (m.ph == 1 || m.ph == 3) begin
      if (m.el + 1 == ylen) begin
        r.ph = e ? 4 : (m.ph + 1) % 4;
        r.el = 0;
      end else begin
        r.el = m.el + 1;
      end
    end else if (!e) begin
      r.ph = 0;
      r.el = 0;
    end
    return r;
  endfunction

  function automatic logic [3:0] lamp_of(int ph);
    logic [3:0] v;
    v = 4'b0000;
    if (ph < 4) v = 4'b1000 >> ph;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= step_m(m1, emergency, 5 * 100, 1 * 100);
      m2 <= step_m(m2, emergency2, 2 * 1, 1 * 1);
    end
  end

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s at %0t: lamps=%b expected=%b",
                 name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_default", l1, lamp_of(m1.ph));
    chk("model_fast", l2, lamp_of(m2.ph));
    n_chk++;
    if ($countones(l1) > 1 || $countones(l2) > 1) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL onehot at %0t: lamps=%b/%b expected at most one",
                 $time, l1, l2);
    end
  end

  task automatic go_to(int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cur = 0;
    reset = 1'b1;
    emergency = 1'b0;
    emergency2 = 1'b0;
    #8;
    chk("reset_default", l1, 4'b1000);
    chk("reset_fast", l2, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    go_to(1); chk("fast_nsg", l2, 4'b1000);
    go_to(2); chk("fast_nsy", l2, 4'b0100);
    go_to(3); chk("fast_ewg", l2, 4'b0010);
    go_to(5); chk("fast_ewy", l2, 4'b0001);
    go_to(6); chk("fast_wrap", l2, 4'b1000);

    go_to(499);  chk("nsg_end", l1, 4'b1000);
    go_to(500);  chk("nsy_start", l1, 4'b0100);
    go_to(599);  chk("nsy_end", l1, 4'b0100);
    go_to(600);  chk("ewg_start", l1, 4'b0010);
    go_to(1100); chk("ewy_start", l1, 4'b0001);
    go_to(1200); chk("cycle_wrap", l1, 4'b1000);

    emergency = 1'b1;
    go_to(1201); chk("emerg_nsy", l1, 4'b0100);
    go_to(1300); chk("emerg_nsy_full", l1, 4'b0100);
    go_to(1301); chk("emerg_red", l1, 4'b0000);
    go_to(1800); chk("emerg_hold", l1, 4'b0000);
    emergency = 1'b0;
    go_to(1801); chk("emerg_release", l1, 4'b1000);
    go_to(2301); chk("resume_nsy", l1, 4'b0100);
    go_to(2901); chk("resume_ewy", l1, 4'b0001);

    go_to(2902);
    emergency = 1'b1;
    go_to(3000); chk("ewy_full", l1, 4'b0001);
    go_to(3001); chk("ewy_to_red", l1, 4'b0000);
    go_to(3010);
    emergency = 1'b0;
    go_to(3011); chk("red_to_nsg", l1, 4'b1000);

    go_to(3111);
    emergency = 1'b1;
    go_to(3112); chk("pulse_nsy", l1, 4'b0100);
    go_to(3114);
    emergency = 1'b0;
    go_to(3211); chk("pulse_nsy_end", l1, 4'b0100);
    go_to(3212); chk("pulse_ewg", l1, 4'b0010);

    go_to(3300);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", l1, 4'b1000);
    emergency = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cur = 0;
    go_to(1); chk("reset_emerg_nsy", l1, 4'b0100);
    go_to(2);
    emergency = 1'b0;
    go_to(100); chk("post_reset_nsy", l1, 4'b0100);
    go_to(101); chk("post_reset_ewg", l1, 4'b0010);
    go_to(1300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
